// File: rtl/if_stage_pkg.sv
// Shared constants, types and helpers for the instruction-fetch stage.
package if_stage_pkg;

  localparam logic        REST_EN  = 1'b0;
  localparam logic [31:0] PC_RESET = 32'h1C00_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Word-align an address; the low two bits of any PC are meaningless.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential PC generation, synchronous SRAM request,
// one-entry skid buffer towards decode, branch redirect and sticky halt.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] PC,
  output logic [31:0] Inst,
  output logic        right_valid,
  input  logic        right_ready
);

  logic [31:0]  r_fetch_pc;
  logic         r_req_valid;
  logic [31:0]  r_req_pc;
  logic         r_hold_valid;
  fetch_entry_t r_hold;
  logic         r_halted;

  logic         w_reset_n;
  logic         w_busy;
  logic         w_right_valid;
  logic         w_fire;
  logic         w_issue;
  logic         w_capture;
  logic [31:0]  w_addr;

  assign w_reset_n     = (reset != REST_EN);
  assign w_busy        = r_hold_valid | r_req_valid;
  assign w_right_valid = w_reset_n & ~redirect_valid & w_busy;
  assign w_fire        = w_right_valid & right_ready;
  // A new request is only made when its response is guaranteed a place to land.
  assign w_issue       = w_reset_n & ~r_halted & ~halt & (redirect_valid | w_fire | ~w_busy);
  assign w_addr        = redirect_valid ? align_pc(redirect_pc) : r_fetch_pc;
  // The SRAM response exists for one cycle only; park it if decode refuses it.
  assign w_capture     = r_req_valid & ~r_hold_valid & ~right_ready & ~redirect_valid;

  assign inst_sram_en   = w_issue;
  assign inst_sram_addr = w_addr;
  assign right_valid    = w_right_valid;

  always_comb begin
    PC   = 32'h0;
    Inst = 32'h0;
    if (w_right_valid) begin
      if (r_hold_valid) begin
        PC   = r_hold.pc;
        Inst = r_hold.inst;
      end else begin
        PC   = r_req_pc;
        Inst = inst_sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!w_reset_n) begin
      r_fetch_pc   <= align_pc(RESET_PC);
      r_req_valid  <= 1'b0;
      r_req_pc     <= 32'h0;
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
      r_halted     <= 1'b0;
    end else begin
      if (halt) begin
        r_halted <= 1'b1;
      end

      if (w_issue) begin
        r_req_valid <= 1'b1;
        r_req_pc    <= w_addr;
        r_fetch_pc  <= w_addr + PC_STEP;
      end else begin
        r_req_valid <= 1'b0;
      end

      if (redirect_valid) begin
        r_hold_valid <= 1'b0;
      end else if (w_capture) begin
        r_hold_valid <= 1'b1;
        r_hold.pc    <= r_req_pc;
        r_hold.inst  <= inst_sram_rdata;
      end else if (r_hold_valid && w_fire) begin
        r_hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed walk through the fetch scenarios, then a
// randomized run checked against an instruction-stream reference model.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h1C00_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] PC;
  logic [31:0] Inst;
  logic        right_valid;
  logic        right_ready;

  int tests = 0;
  int fails = 0;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_rdata(inst_sram_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .PC             (PC),
    .Inst           (Inst),
    .right_valid    (right_valid),
    .right_ready    (right_ready)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM model: one-cycle read latency, contents derived from address.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ KEY;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic chk_pres(input string tag, input logic [31:0] pc_v);
    chk({tag, ".valid"}, {31'h0, right_valid}, 32'd1);
    chk({tag, ".pc"}, PC, pc_v);
    chk({tag, ".inst"}, Inst, pc_v ^ KEY);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, {31'h0, right_valid}, 32'd0);
    chk({tag, ".en"}, {31'h0, inst_sram_en}, 32'd0);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] addr_v);
    chk({tag, ".en"}, {31'h0, inst_sram_en}, 32'd1);
    chk({tag, ".addr"}, inst_sram_addr, addr_v);
  endtask

  // Reference model state for the random phase.
  logic [31:0] exp_pc;
  logic        halted_m;
  logic        prev_stall;
  logic [31:0] prev_pc;
  logic        prev_en;

  initial begin
    reset = 1'b0; right_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt = 1'b0;
    tick(); tick();
    look();
    chk_idle("rst");
    chk("rst.pc", PC, 32'h0);
    chk("rst.inst", Inst, 32'h0);

    // Streaming fetch after reset release.
    tick(); reset = 1'b1;
    look(); chk_req("a", 32'h1C00_0000); chk("a.valid", {31'h0, right_valid}, 32'd0);
    tick();
    look(); chk_pres("b", 32'h1C00_0000); chk_req("b", 32'h1C00_0004);
    tick();

    // Back-pressure for three cycles on the 0x..04 response.
    right_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      look(); chk_pres("stall", 32'h1C00_0004);
      chk("stall.en", {31'h0, inst_sram_en}, 32'd0);
      tick();
    end
    right_ready = 1'b1;
    look(); chk_pres("drain", 32'h1C00_0004); chk_req("drain", 32'h1C00_0008);
    tick();

    // Fill the hold buffer, then redirect on top of it.
    right_ready = 1'b0;
    look(); chk_pres("g", 32'h1C00_0008); chk("g.en", {31'h0, inst_sram_en}, 32'd0);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h1C00_0103;
    look(); chk("redir.valid", {31'h0, right_valid}, 32'd0); chk_req("redir", 32'h1C00_0100);
    tick();
    redirect_valid = 1'b0; right_ready = 1'b1;
    look(); chk_pres("tgt", 32'h1C00_0100); chk_req("tgt", 32'h1C00_0104);
    tick();

    // Halt with one response live: it is delivered, then the stage goes quiet.
    halt = 1'b1;
    look(); chk_pres("halt", 32'h1C00_0104); chk("halt.en", {31'h0, inst_sram_en}, 32'd0);
    tick();
    halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      look(); chk_idle("halted");
      tick();
    end
    reset = 1'b0;
    look(); chk_idle("rst2");
    tick();
    reset = 1'b1;
    look(); chk_req("restart", RST_PC);
    tick();
    look(); chk_pres("m", RST_PC); chk_req("m", 32'h1C00_0004);
    tick();

    // Redirect + halt + no ready with the hold buffer full.
    right_ready = 1'b0;
    look(); chk_pres("n", 32'h1C00_0004);
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h2000_0000; halt = 1'b1;
    look(); chk_idle("rdhalt");
    tick();
    redirect_valid = 1'b0; halt = 1'b0; right_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      look(); chk_idle("rdhalt.after");
      tick();
    end

    // Reset while a stalled instruction sits in the hold buffer.
    reset = 1'b0;
    tick();
    reset = 1'b1; right_ready = 1'b0;
    tick();
    look(); chk_pres("r", RST_PC);
    tick();
    look(); chk_pres("s", RST_PC);
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1; right_ready = 1'b1;
    look(); chk("t.valid", {31'h0, right_valid}, 32'd0); chk_req("t", RST_PC);
    tick();

    // Address wrap at the top of the space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    look(); chk_req("wrap0", 32'hFFFF_FFFC);
    tick();
    redirect_valid = 1'b0;
    look(); chk_pres("wrap1", 32'hFFFF_FFFC); chk_req("wrap1", 32'h0000_0000);
    tick();
    look(); chk_pres("wrap2", 32'h0000_0000);
    tick();

    // Randomized phase: the delivered stream must be contiguous from the last
    // reset or redirect target, with each word matching its address.
    reset = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    tick();
    exp_pc = RST_PC; halted_m = 1'b0; prev_stall = 1'b0; prev_pc = 32'h0; prev_en = 1'b0;
    for (int i = 0; i < 800; i++) begin
      logic fire, stall;
      reset          = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      right_ready    = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_pc    = $urandom;
      halt           = ($urandom_range(0, 299) < 1);
      look();
      if (!reset) begin
        chk_idle("rnd.rst");
      end else begin
        if (redirect_valid) begin
          chk("rnd.redir.valid", {31'h0, right_valid}, 32'd0);
          if (!halted_m && !halt) chk_req("rnd.redir", redirect_pc & ~32'h3);
        end
        if (halted_m || halt) chk("rnd.halt.en", {31'h0, inst_sram_en}, 32'd0);
        if (right_valid) begin
          chk("rnd.pc", PC, exp_pc);
          chk("rnd.inst", Inst, PC ^ KEY);
        end else begin
          chk("rnd.pc0", PC, 32'h0);
          chk("rnd.inst0", Inst, 32'h0);
        end
        if (prev_stall && !redirect_valid) chk_pres("rnd.hold", prev_pc);
        if (prev_en && !redirect_valid) chk("rnd.lat", {31'h0, right_valid}, 32'd1);
      end
      fire    = right_valid & right_ready;
      stall   = reset & right_valid & ~right_ready & ~redirect_valid;
      prev_pc = PC;
      prev_en = inst_sram_en;
      @(posedge clk);
      if (!reset) begin
        exp_pc   = RST_PC;
        halted_m = 1'b0;
      end else begin
        if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
        else if (fire) exp_pc = exp_pc + 32'd4;
        if (halt) halted_m = 1'b1;
      end
      prev_stall = stall;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
